// File: rtl/carfield_boot_seq.sv
`default_nettype none
// ============================================================================
// Module   : carfield_boot_seq
// Purpose  : Power-on boot sequencer for the Carfield SoC domains. Releases
//            domains in index order: security island, host, safety island,
//            accelerators. For each domain it enables the clock, waits for the
//            clock to settle, releases the reset and waits for ready. After
//            boot it serves per-domain software re-reset requests.
// Ports    : clk_i         system clock
//            rst_ni        power-on reset, asynchronous, active-low
//            test_mode_i   bypass: all clocks on, resets follow rst_ni
//            ready_i       per-domain ready flag (synchronous to clk_i)
//            sw_rst_req_i  per-domain re-reset request (single-cycle pulse)
//            clk_en_o      per-domain clock-gate enable
//            rst_no        per-domain reset, active-low
//            done_o        boot complete and no re-reset in progress
//            error_o       sticky ready-timeout flag
//            err_idx_o     index of the domain that timed out
// Config   : CARFIELD_BOOT_SEQ_TIMEOUT_EN enables ready timeouts and the
//            ERROR state; when undefined the FSM waits for ready forever and
//            error_o / err_idx_o are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module carfield_boot_seq #(
  parameter int unsigned NumDomains      = 4,
  parameter int unsigned ClkSettleCycles = 4,
  parameter int unsigned RstHoldCycles   = 16,
  parameter int unsigned TimeoutCycles   = 1024,
  parameter int unsigned CntWidth        = $clog2(
      ((ClkSettleCycles > RstHoldCycles) ?
        ((ClkSettleCycles > TimeoutCycles) ? ClkSettleCycles : TimeoutCycles) :
        ((RstHoldCycles   > TimeoutCycles) ? RstHoldCycles   : TimeoutCycles)) + 1),
  localparam int unsigned IdxWidth       = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  test_mode_i,
  input  logic [NumDomains-1:0] ready_i,
  input  logic [NumDomains-1:0] sw_rst_req_i,
  output logic [NumDomains-1:0] clk_en_o,
  output logic [NumDomains-1:0] rst_no,
  output logic                  done_o,
  output logic                  error_o,
  output logic [IdxWidth-1:0]   err_idx_o
);

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumDomains - 1);

  typedef enum logic [2:0] {
    S_CLK_EN  = 3'd0,
    S_RST_REL = 3'd1,
    S_DONE    = 3'd2,
    S_SW_HOLD = 3'd3,
    S_SW_WAIT = 3'd4,
    S_ERROR   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [IdxWidth-1:0]   idx_q, idx_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;

  // FSM view of the domain controls (before the test-mode override).
  logic [NumDomains-1:0] clk_en_q, clk_en_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;

  // Output registers: the test-mode override is folded in before the flop so
  // that no input reaches an output combinationally.
  logic [NumDomains-1:0] clk_en_out_q;
  logic [NumDomains-1:0] rst_n_out_q;
  logic                  done_out_q;

  logic [IdxWidth-1:0]   sw_idx;

  // Lowest set request bit wins; the others are simply dropped.
  always_comb begin
    sw_idx = '0;
    for (int i = int'(NumDomains) - 1; i >= 0; i--) begin
      if (sw_rst_req_i[i]) sw_idx = IdxWidth'(i);
    end
  end

`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
  logic                  error_q, error_d;
  logic [IdxWidth-1:0]   err_idx_q, err_idx_d;
`endif

  // Each timed state applies its action in its first cycle and then counts
  // a further N cycles, so clk_en rises ClkSettleCycles cycles before the
  // reset release and a re-reset holds rst_no low for RstHoldCycles cycles.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    clk_en_d = clk_en_q;
    rst_n_d  = rst_n_q;
    done_d   = done_q;
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
    error_d   = error_q;
    err_idx_d = err_idx_q;
`endif
    case (state_q)
      S_CLK_EN: begin
        clk_en_d[idx_q] = 1'b1;
        if (cnt_q == CntWidth'(ClkSettleCycles)) begin
          state_d        = S_RST_REL;
          cnt_d          = '0;
          rst_n_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      S_RST_REL, S_SW_WAIT: begin
        // Ready is checked before the timeout so a coincident ready wins.
        if (ready_i[idx_q]) begin
          cnt_d = '0;
          if (state_q == S_SW_WAIT || idx_q == LastIdx) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_CLK_EN;
            idx_d   = idx_q + IdxWidth'(1);
          end
        end
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
        else if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
          // The unresponsive domain goes back into reset; its clock stays on.
          state_d        = S_ERROR;
          error_d        = 1'b1;
          err_idx_d      = idx_q;
          rst_n_d[idx_q] = 1'b0;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
`endif
      end
      S_DONE: begin
        if (|sw_rst_req_i) begin
          state_d = S_SW_HOLD;
          idx_d   = sw_idx;
          cnt_d   = '0;
        end
      end
      S_SW_HOLD: begin
        rst_n_d[idx_q] = 1'b0;
        done_d         = 1'b0;
        if (cnt_q == CntWidth'(RstHoldCycles)) begin
          state_d        = S_SW_WAIT;
          cnt_d          = '0;
          rst_n_d[idx_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
      S_ERROR: begin
        // Terminal until power-on reset.
        state_d = S_ERROR;
      end
`endif
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_CLK_EN;
      idx_q        <= '0;
      cnt_q        <= '0;
      clk_en_q     <= '0;
      rst_n_q      <= '0;
      done_q       <= 1'b0;
      clk_en_out_q <= '0;
      rst_n_out_q  <= '0;
      done_out_q   <= 1'b0;
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
      error_q      <= 1'b0;
      err_idx_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      clk_en_q     <= clk_en_d;
      rst_n_q      <= rst_n_d;
      done_q       <= done_d;
      clk_en_out_q <= test_mode_i ? '1 : clk_en_d;
      rst_n_out_q  <= test_mode_i ? '1 : rst_n_d;
      done_out_q   <= test_mode_i | done_d;
`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
      error_q      <= error_d;
      err_idx_q    <= err_idx_d;
`endif
    end
  end

  assign clk_en_o = clk_en_out_q;
  assign rst_no   = rst_n_out_q;
  assign done_o   = done_out_q;

`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
  assign error_o   = error_q;
  assign err_idx_o = err_idx_q;
`else
  assign error_o   = 1'b0;
  assign err_idx_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_carfield_boot_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_carfield_boot_seq
// Purpose  : Directed self-checking bench for carfield_boot_seq with
//            NumDomains=3, ClkSettleCycles=4, RstHoldCycles=16,
//            TimeoutCycles=64. Inputs change and outputs are sampled on the
//            falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_carfield_boot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       test_mode;
  logic [2:0] ready;
  logic [2:0] sw_req;
  logic [2:0] clk_en;
  logic [2:0] rst_o;
  logic       done;
  logic       error;
  logic [1:0] err_idx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  carfield_boot_seq #(
    .NumDomains     (3),
    .ClkSettleCycles(4),
    .RstHoldCycles  (16),
    .TimeoutCycles  (64)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .test_mode_i (test_mode),
    .ready_i     (ready),
    .sw_rst_req_i(sw_req),
    .clk_en_o    (clk_en),
    .rst_no      (rst_o),
    .done_o      (done),
    .error_o     (error),
    .err_idx_o   (err_idx)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst_n  = 1'b0;
    sw_req = '0;
    step(2);
  endtask

  // Starts at the falling edge before the first CLK_EN cycle of domain k.
  // Raises ready[k] dly cycles after rst_no[k] rises and ends at the falling
  // edge right after the edge that samples it. req is pulsed in cycle one.
  task automatic seq_domain(input int k, input int dly, input logic [2:0] req);
    logic [2:0] m_lo;
    logic [2:0] m;
    m_lo   = 3'((1 << k) - 1);
    m      = 3'((1 << (k + 1)) - 1);
    sw_req = req;
    step(1);
    sw_req = '0;
    chk($sformatf("clk_en_rise_d%0d", k), clk_en, m);
    chk($sformatf("rst_held_d%0d", k), rst_o, m_lo);
    step(3);
    chk($sformatf("settle_clk_en_d%0d", k), clk_en, m);
    chk($sformatf("settle_rst_d%0d", k), rst_o, m_lo);
    step(1);
    chk($sformatf("rst_release_d%0d", k), rst_o, m);
    step(dly);
    chk($sformatf("wait_done_low_d%0d", k), {2'b00, done}, 3'd0);
    ready[k] = 1'b1;
    step(1);
  endtask

  initial begin
    rst_n     = 1'b0;
    test_mode = 1'b0;
    ready     = '0;
    sw_req    = '0;

    // ---------------- reset state and nominal boot ----------------
    apply_reset();
    chk("reset_clk_en", clk_en, 3'b000);
    chk("reset_rst", rst_o, 3'b000);
    chk("reset_done", {2'b00, done}, 3'd0);
    chk("reset_error", {2'b00, error}, 3'd0);
    chk("reset_err_idx", {1'b0, err_idx}, 3'd0);
    rst_n = 1'b1;
    seq_domain(0, 10, 3'b000);
    seq_domain(1, 10, 3'b000);
    seq_domain(2, 10, 3'b000);
    chk("boot_done", {2'b00, done}, 3'd1);
    chk("boot_rst_all", rst_o, 3'b111);
    chk("boot_clk_all", clk_en, 3'b111);
    chk("boot_no_error", {2'b00, error}, 3'd0);

    // ---------------- software re-reset, 3'b110 ----------------
    ready[1] = 1'b0;
    sw_req   = 3'b110;
    step(1);
    sw_req = '0;
    chk("swhold_entry_done", {2'b00, done}, 3'd1);
    chk("swhold_entry_rst", rst_o, 3'b111);
    step(1);
    chk("swhold_done_low", {2'b00, done}, 3'd0);
    chk("swhold_rst", rst_o, 3'b101);
    chk("swhold_clk", clk_en, 3'b111);
    step(15);
    chk("swhold_rst_16th", rst_o, 3'b101);
    step(1);
    chk("swwait_rst", rst_o, 3'b111);
    step(5);
    chk("swwait_done_low", {2'b00, done}, 3'd0);
    ready[1] = 1'b1;
    step(1);
    chk("swwait_done_back", {2'b00, done}, 3'd1);
    step(30);
    chk("bit2_dropped_rst", rst_o, 3'b111);
    chk("bit2_dropped_done", {2'b00, done}, 3'd1);

    // ---------------- early ready, request during boot ----------------
    apply_reset();
    ready = 3'b111;
    rst_n = 1'b1;
    seq_domain(0, 0, 3'b000);
    seq_domain(1, 0, 3'b001);
    seq_domain(2, 0, 3'b000);
    chk("early_done", {2'b00, done}, 3'd1);
    step(25);
    chk("early_req_ignored_rst", rst_o, 3'b111);
    chk("early_req_ignored_done", {2'b00, done}, 3'd1);

    // ---------------- reset mid-sequence ----------------
    apply_reset();
    ready = 3'b000;
    rst_n = 1'b1;
    seq_domain(0, 3, 3'b000);
    step(5);
    chk("mid_rstrel_d1", rst_o, 3'b011);
    step(2);
    rst_n = 1'b0;
    #1;
    chk("mid_async_clk", clk_en, 3'b000);
    chk("mid_async_rst", rst_o, 3'b000);
    chk("mid_async_done", {2'b00, done}, 3'd0);
    step(2);
    ready = 3'b000;
    rst_n = 1'b1;
    seq_domain(0, 2, 3'b000);
    step(1);
    chk("mid_restart_clk", clk_en, 3'b011);
    chk("mid_restart_rst", rst_o, 3'b001);

    // ---------------- bypass ----------------
    apply_reset();
    test_mode = 1'b1;
    ready     = 3'b000;
    chk("bypass_in_reset_rst", rst_o, 3'b000);
    rst_n = 1'b1;
    step(1);
    chk("bypass_clk", clk_en, 3'b111);
    chk("bypass_rst", rst_o, 3'b111);
    chk("bypass_done", {2'b00, done}, 3'd1);
    step(5);
    test_mode = 1'b0;
    step(1);
    chk("bypass_exit_clk", clk_en, 3'b001);
    chk("bypass_exit_rst", rst_o, 3'b001);
    chk("bypass_exit_done", {2'b00, done}, 3'd0);

`ifdef CARFIELD_BOOT_SEQ_TIMEOUT_EN
    // ---------------- ready timeout on domain 1 ----------------
    apply_reset();
    ready = 3'b000;
    rst_n = 1'b1;
    seq_domain(0, 10, 3'b000);
    step(5);
    chk("to_rst_rel_d1", rst_o, 3'b011);
    step(63);
    chk("to_not_yet", {2'b00, error}, 3'd0);
    step(1);
    chk("to_error", {2'b00, error}, 3'd1);
    chk("to_err_idx", {1'b0, err_idx}, 3'd1);
    chk("to_rst", rst_o, 3'b001);
    chk("to_clk", clk_en, 3'b011);
    ready[1] = 1'b1;
    step(100);
    chk("to_sticky", {2'b00, error}, 3'd1);
    chk("to_rst_later", rst_o, 3'b001);
    chk("to_clk_later", clk_en, 3'b011);
    chk("to_done", {2'b00, done}, 3'd0);
`else
    // ---------------- no-timeout build ----------------
    apply_reset();
    ready = 3'b000;
    rst_n = 1'b1;
    step(5);
    chk("nt_rst_rel_d0", rst_o, 3'b001);
    step(1000);
    chk("nt_no_error", {2'b00, error}, 3'd0);
    chk("nt_still_waiting_rst", rst_o, 3'b001);
    chk("nt_still_waiting_clk", clk_en, 3'b001);
    ready[0] = 1'b1;
    step(2);
    chk("nt_next_domain_clk", clk_en, 3'b011);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
